// File: rtl/pipeline_sequencer_pkg.sv
// Shared state encodings and timing constants for the pipeline run/halt/step
// sequencer.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_RUN        = 3'd1,
    S_DRAIN      = 3'd2,
    S_HALTED     = 3'd3,
    S_STEP       = 3'd4
  } seq_state_t;

  // One drain cycle each for ID/EX, EX/MEM and MEM/WB.
  localparam int DRAIN_LEN = 3;
  localparam int DRAIN_W   = 2;

  function automatic logic is_issue_state(input seq_state_t s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination feeds either source of the instruction in ID.
module load_use_detector (
  input  logic       ID_EX_mem_read,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  output logic       lu
);

  // $zero is never a real dependency.
  assign lu = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
              ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/halt/single-step sequencer and load-use stall controller driving the
// PC, IF/ID and hazard-mux controls of the five-stage datapath.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter bit START_HALTED = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             take_branch,
  input  logic             ID_EX_mem_read,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             mux_hz_sel,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  seq_state_t         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               step_active;
  logic               lu;
  logic               issuing;

  load_use_detector u_lud (
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rt       (ID_EX_rt),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .lu             (lu)
  );

  assign issuing = is_issue_state(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RESET_HOLD;
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      step_active <= 1'b0;
      halted      <= 1'b0;
      step_done   <= 1'b0;
      issue_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      step_done <= 1'b0;
      halted    <= 1'b0;

      if (issuing) begin
        if (lu) stall_cnt <= stall_cnt + 1'b1;
        else    issue_cnt <= issue_cnt + 1'b1;
      end

      case (state)
        S_RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (START_HALTED) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (halt_req) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= S_HALTED;
            halted <= 1'b1;
            if (step_active) begin
              step_done   <= 1'b1;
              step_active <= 1'b0;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        S_HALTED: begin
          if (run_req) begin
            state <= S_RUN;
          end else if (step_req) begin
            state       <= S_STEP;
            step_active <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end

        S_STEP: begin
          // The step's one instruction leaves IF/ID on the first stall-free cycle.
          if (!lu) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end

        default: begin
          state    <= S_RESET_HOLD;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Freeze keeps IF/ID intact so the held instruction re-issues on resume.
  always_comb begin
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    mux_hz_sel  = 1'b1;
    if (issuing && !lu) begin
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = take_branch;
      mux_hz_sel  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed-vector bench for pipeline_sequencer: reset/start, load-use, branch,
// halt/drain, single-step and mid-drain reset.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, halt_req, step_req, take_branch;
  logic        ID_EX_mem_read;
  logic [4:0]  ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic        pc_write, IF_ID_write, IF_ID_flush, mux_hz_sel;
  logic        halted, step_done;
  logic [15:0] issue_cnt, stall_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_issue = 16'd0;
  logic [15:0] exp_stall = 16'd0;

  localparam logic [3:0] FRZ   = 4'b0001;
  localparam logic [3:0] ISS   = 4'b1100;
  localparam logic [3:0] ISS_F = 4'b1110;

  wire [3:0] ctl = {pc_write, IF_ID_write, IF_ID_flush, mux_hz_sel};

  pipeline_sequencer #(.HOLD_CYCLES(4), .START_HALTED(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .take_branch(take_branch),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .mux_hz_sel(mux_hz_sel), .halted(halted), .step_done(step_done),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Move to the next cycle; registered outputs are settled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic on);
    ID_EX_mem_read = on;
    ID_EX_rt       = on ? 5'd8 : 5'd0;
    IF_ID_rs       = on ? 5'd8 : 5'd3;
    IF_ID_rt       = 5'd4;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_req = 0; halt_req = 0; step_req = 0; take_branch = 0;
    set_lu(1'b0);
    cyc(); cyc();
    n_vec++;
    if (ctl !== FRZ || halted !== 1'b0 || step_done !== 1'b0 ||
        issue_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_hold: ctl=%b h=%b sd=%b ic=%0d sc=%0d want ctl=%b 0 0 0 0",
               ctl, halted, step_done, issue_cnt, stall_cnt, FRZ);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (ctl !== FRZ || halted !== 1'b0 || issue_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: ctl=%b h=%b ic=%0d want ctl=%b h=0 ic=0",
                 i, ctl, halted, issue_cnt, FRZ);
      end
      cyc();
    end
    #1;
    n_vec++;
    if (ctl !== ISS || issue_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL first_run: ctl=%b ic=%0d want ctl=%b ic=0", ctl, issue_cnt, ISS);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      exp_issue++;
      n_vec++;
      if (issue_cnt !== exp_issue) begin
        n_bad++;
        $display("FAIL issue_inc%0d: ic=%0d want %0d", i, issue_cnt, exp_issue);
      end
    end
  endtask

  task automatic test_load_use();
    set_lu(1'b1);
    #1;
    n_vec++;
    if (ctl !== FRZ) begin
      n_bad++;
      $display("FAIL lu_rs_stall: ctl=%b want %b", ctl, FRZ);
    end
    cyc(); exp_stall++;
    n_vec++;
    if (stall_cnt !== exp_stall || issue_cnt !== exp_issue) begin
      n_bad++;
      $display("FAIL lu_stall_cnt: sc=%0d ic=%0d want %0d %0d",
               stall_cnt, issue_cnt, exp_stall, exp_issue);
    end
    // Match through rt rather than rs.
    ID_EX_mem_read = 1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd1; IF_ID_rt = 5'd5;
    #1;
    n_vec++;
    if (ctl !== FRZ) begin
      n_bad++;
      $display("FAIL lu_rt_stall: ctl=%b want %b", ctl, FRZ);
    end
    cyc(); exp_stall++;
    // Destination $zero never stalls.
    ID_EX_mem_read = 1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    #1;
    n_vec++;
    if (ctl !== ISS) begin
      n_bad++;
      $display("FAIL lu_zero_reg: ctl=%b want %b", ctl, ISS);
    end
    cyc(); exp_issue++;
    // Matching regs but not a load.
    ID_EX_mem_read = 0; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    #1;
    n_vec++;
    if (ctl !== ISS) begin
      n_bad++;
      $display("FAIL lu_not_load: ctl=%b want %b", ctl, ISS);
    end
    cyc(); exp_issue++;
    set_lu(1'b0);
    n_vec++;
    if (stall_cnt !== exp_stall || issue_cnt !== exp_issue) begin
      n_bad++;
      $display("FAIL lu_counts: sc=%0d ic=%0d want %0d %0d",
               stall_cnt, issue_cnt, exp_stall, exp_issue);
    end
  endtask

  task automatic test_branch();
    take_branch = 1'b1;
    #1;
    n_vec++;
    if (ctl !== ISS_F) begin
      n_bad++;
      $display("FAIL branch_flush: ctl=%b want %b", ctl, ISS_F);
    end
    cyc(); exp_issue++;
    set_lu(1'b1);
    #1;
    n_vec++;
    if (ctl !== FRZ) begin
      n_bad++;
      $display("FAIL branch_vs_lu: ctl=%b want %b", ctl, FRZ);
    end
    cyc(); exp_stall++;
    set_lu(1'b0); take_branch = 1'b0;
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    n_vec++;
    if (ctl !== ISS) begin
      n_bad++;
      $display("FAIL halt_cycle_n: ctl=%b want %b", ctl, ISS);
    end
    cyc(); exp_issue++;
    for (int i = 1; i <= 3; i++) begin
      run_req = (i == 2);
      #1;
      n_vec++;
      if (ctl !== FRZ || halted !== 1'b0) begin
        n_bad++;
        $display("FAIL drain%0d: ctl=%b h=%b want %b h=0", i, ctl, halted, FRZ);
      end
      cyc();
    end
    run_req = 1'b0;
    n_vec++;
    if (halted !== 1'b1 || ctl !== FRZ || step_done !== 1'b0) begin
      n_bad++;
      $display("FAIL halted_n4: h=%b ctl=%b sd=%b want 1 %b 0", halted, ctl, step_done, FRZ);
    end
    cyc();
    halt_req = 1'b0;
    n_vec++;
    if (halted !== 1'b1 || issue_cnt !== exp_issue || stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL halted_hold: h=%b ic=%0d sc=%0d want 1 %0d %0d",
               halted, issue_cnt, stall_cnt, exp_issue, exp_stall);
    end
    run_req = 1'b1; step_req = 1'b1;
    cyc();
    run_req = 1'b0; step_req = 1'b0;
    #1;
    n_vec++;
    if (ctl !== ISS || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_run: ctl=%b h=%b want %b 0", ctl, halted, ISS);
    end
    cyc(); exp_issue++;
  endtask

  task automatic enter_halted();
    halt_req = 1'b1;
    cyc(); exp_issue++;
    halt_req = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_step();
    enter_halted();
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    set_lu(1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (ctl !== FRZ || halted !== 1'b0) begin
        n_bad++;
        $display("FAIL step_stall%0d: ctl=%b h=%b want %b 0", i, ctl, halted, FRZ);
      end
      cyc(); exp_stall++;
    end
    set_lu(1'b0);
    #1;
    n_vec++;
    if (ctl !== ISS) begin
      n_bad++;
      $display("FAIL step_issue: ctl=%b want %b", ctl, ISS);
    end
    cyc(); exp_issue++;
    for (int i = 1; i <= 3; i++) begin
      n_vec++;
      if (ctl !== FRZ || step_done !== 1'b0 || halted !== 1'b0) begin
        n_bad++;
        $display("FAIL step_drain%0d: ctl=%b sd=%b h=%b want %b 0 0",
                 i, ctl, step_done, halted, FRZ);
      end
      cyc();
    end
    n_vec++;
    if (step_done !== 1'b1 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL step_done_pulse: sd=%b h=%b want 1 1", step_done, halted);
    end
    cyc();
    n_vec++;
    if (step_done !== 1'b0 || halted !== 1'b1 ||
        issue_cnt !== exp_issue || stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL step_after: sd=%b h=%b ic=%0d sc=%0d want 0 1 %0d %0d",
               step_done, halted, issue_cnt, stall_cnt, exp_issue, exp_stall);
    end
  endtask

  task automatic test_mid_drain_reset();
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    n_vec++;
    if (ctl !== FRZ || issue_cnt !== 16'd0 || stall_cnt !== 16'd0 ||
        halted !== 1'b0 || step_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_drain_rst: ctl=%b ic=%0d sc=%0d h=%b sd=%b want %b 0 0 0 0",
               ctl, issue_cnt, stall_cnt, halted, step_done, FRZ);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (step_done !== 1'b0 || ctl !== FRZ) begin
        n_bad++;
        $display("FAIL post_rst_hold%0d: sd=%b ctl=%b want 0 %b", i, step_done, ctl, FRZ);
      end
      cyc();
    end
    #1;
    n_vec++;
    if (ctl !== ISS || step_done !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst_run: ctl=%b sd=%b h=%b want %b 0 0", ctl, step_done, halted, ISS);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_halt();
    test_step();
    test_mid_drain_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
